pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL take parameter PC_W, default 32: width of PC, target and fetch address.
REQ-002 SHALL take parameter RESET_PC, default 0: PC value loaded on reset.
REQ-003 SHALL take parameter TIMEOUT, default 15: maximum WAIT cycles before error.
REQ-004 in_clk  input  1  single clock; all state updates on its rising edge.
REQ-005 in_rst  input  1  reset; synchronous, active-high.
REQ-006 in_stall  input  1  downstream not ready; holds the presented instruction.
REQ-007 in_imem_ack  input  1  instruction memory returns data this cycle.
REQ-008 in_imem_data  input  32  instruction word, valid with in_imem_ack.
REQ-009 in_resolve  input  1  branch/jump decision presented this cycle.
REQ-010 in_ctrl_branch, in_ctrl_btype, in_ctrl_jump, in_ctrl_neg, in_ctrl_zero  input  1 each  decision qualifiers, sampled only with in_resolve; btype 0 = BRZ, 1 = BRN.
REQ-011 in_target  input  PC_W  redirect address, sampled with in_resolve.
REQ-012 out_imem_req  output  1  fetch request.
REQ-013 out_imem_addr  output  PC_W  fetch address; equals the PC register.
REQ-014 out_instr  output  32  captured instruction.
REQ-015 out_instr_valid  output  1  out_instr valid.
REQ-016 out_pc  output  PC_W  address of out_instr.
REQ-017 out_flush  output  1  one-cycle pulse on taken redirect.
REQ-018 out_err  output  1  sticky fetch-timeout flag.

Function
REQ-019 Taken SHALL equal in_resolve & (jump | branch&!btype&zero | branch&btype&neg).
REQ-020 FSM states SHALL be FETCH, WAIT, HOLD, ERR.
REQ-021 FETCH: out_imem_req=1 for one cycle, then WAIT.
REQ-022 WAIT: out_imem_req=1; on ack: out_instr<=data, out_pc<=PC, PC<=PC+1 (mod 2^PC_W), out_instr_valid<=1, go to HOLD.
REQ-023 HOLD: out_imem_req=0; out_instr, out_pc and out_instr_valid held while in_stall=1; when in_stall=0, out_instr_valid<=0 next cycle and FSM goes to FETCH.
REQ-024 Fetch-to-valid latency SHALL be 1 cycle after the ack edge; with the memory acking in the first WAIT cycle and in_stall=0, throughput is one instruction per 3 cycles.
REQ-025 A taken resolve in any non-ERR state SHALL set PC<=in_target, pulse out_flush for exactly one cycle, clear out_instr_valid, and go to FETCH.
REQ-026 Taken resolve coincident with ack SHALL win: data discarded, PC not incremented.
REQ-027 Taken resolve during HOLD with in_stall=1 SHALL still redirect; the held instruction is dropped.
REQ-028 A not-taken resolve SHALL have no effect.
REQ-029 WAIT SHALL count cycles with a 4-bit saturating counter, cleared on entry to WAIT.
REQ-030 On the TIMEOUT-th WAIT cycle without ack, the FSM SHALL go to ERR and set out_err.
REQ-031 ERR: out_imem_req=0 and out_instr_valid=0; resolve is ignored; only reset exits ERR.

Reset
REQ-032 Reset SHALL set PC=RESET_PC, state=FETCH, out_instr=0, out_pc=0, out_instr_valid=0, out_flush=0, out_err=0, and the counter to 0.
REQ-033 Reset SHALL take priority over ack, resolve and stall in the same cycle; an in-flight fetch is abandoned.
REQ-034 out_imem_req SHALL first assert in the cycle after reset deasserts.

Structure
REQ-035 FSM state encoding, RESET_PC and TIMEOUT defaults SHALL live in the shared cpu package.
REQ-036 The taken equation SHALL be the single sub-module branch_decide; no other hierarchy.

Verification
REQ-037 Reset, then ack on the first WAIT cycle with data 0xA5A5A5A5, stall 0 -> out_imem_addr 0, out_instr=0xA5A5A5A5 with out_pc=0, next fetch address 1.
REQ-038 Stall high for 4 cycles during HOLD -> valid, instr and pc stable for all 4 cycles; no request until stall drops.
REQ-039 Resolve with branch=1, btype=1, neg=1, target 0x40, coincident with ack -> flush pulse of 1 cycle, data dropped, next address 0x40.
REQ-040 Resolve with branch=1, btype=0, zero=0 -> no flush, PC sequence unchanged; jump=1 target 0x10 -> next address 0x10.
REQ-041 No ack for 15 WAIT cycles -> out_err=1, req=0, resolve ignored; in_rst=1 for one cycle -> all outputs cleared, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared cpu package: fetch sequencer state encoding, parameter defaults
// and small arithmetic helpers used by the PC sequencer.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_ERR   = 2'd3
  } seq_state_e;

  localparam int unsigned DEFAULT_PC_W     = 32;
  localparam int unsigned DEFAULT_RESET_PC = 0;
  localparam int unsigned DEFAULT_TIMEOUT  = 15;
  localparam int unsigned WAIT_CNT_W       = 4;

  // Saturating increment for the WAIT cycle counter.
  function automatic logic [WAIT_CNT_W-1:0] sat_inc(input logic [WAIT_CNT_W-1:0] v);
    logic [WAIT_CNT_W-1:0] r;
    if (v == {WAIT_CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/pc_sequencer_branch_decide.sv
// Branch/jump decision: a resolve is taken on a jump, a BRZ with zero set,
// or a BRN with neg set.
module branch_decide (
  input  logic resolve,
  input  logic branch,
  input  logic btype,
  input  logic jump,
  input  logic neg,
  input  logic zero,
  output logic taken
);

  assign taken = resolve & (jump | (branch & ~btype & zero) | (branch & btype & neg));

endmodule

// File: rtl/pc_sequencer.sv
// Instruction fetch sequencer: walks the PC through FETCH/WAIT/HOLD, captures
// returned instructions, redirects on taken resolves and traps on fetch timeout.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned       PC_W     = DEFAULT_PC_W,
  parameter logic [PC_W-1:0]   RESET_PC = PC_W'(DEFAULT_RESET_PC),
  parameter int unsigned       TIMEOUT  = DEFAULT_TIMEOUT
) (
  input  logic            in_clk,
  input  logic            in_rst,
  input  logic            in_stall,
  input  logic            in_imem_ack,
  input  logic [31:0]     in_imem_data,
  input  logic            in_resolve,
  input  logic            in_ctrl_branch,
  input  logic            in_ctrl_btype,
  input  logic            in_ctrl_jump,
  input  logic            in_ctrl_neg,
  input  logic            in_ctrl_zero,
  input  logic [PC_W-1:0] in_target,
  output logic            out_imem_req,
  output logic [PC_W-1:0] out_imem_addr,
  output logic [31:0]     out_instr,
  output logic            out_instr_valid,
  output logic [PC_W-1:0] out_pc,
  output logic            out_flush,
  output logic            out_err
);

  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_LAST = WAIT_CNT_W'(TIMEOUT - 1);

  seq_state_e            state_r;
  seq_state_e            state_next_s;
  logic [PC_W-1:0]       pc_r;
  logic [31:0]           instr_r;
  logic [PC_W-1:0]       instr_pc_r;
  logic                  valid_r;
  logic                  flush_r;
  logic                  err_r;
  logic [WAIT_CNT_W-1:0] cnt_r;

  logic taken_s;
  logic load_s;
  logic redirect_s;
  logic clr_valid_s;
  logic cnt_clr_s;
  logic cnt_inc_s;
  logic set_err_s;

  branch_decide u_branch_decide (
    .resolve (in_resolve),
    .branch  (in_ctrl_branch),
    .btype   (in_ctrl_btype),
    .jump    (in_ctrl_jump),
    .neg     (in_ctrl_neg),
    .zero    (in_ctrl_zero),
    .taken   (taken_s)
  );

  // Next-state and datapath strobes; a taken resolve outranks ack and timeout.
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    redirect_s   = 1'b0;
    clr_valid_s  = 1'b0;
    cnt_clr_s    = 1'b0;
    cnt_inc_s    = 1'b0;
    set_err_s    = 1'b0;
    case (state_r)
      ST_FETCH: begin
        if (taken_s) begin
          redirect_s = 1'b1;
        end else begin
          state_next_s = ST_WAIT;
          cnt_clr_s    = 1'b1;
        end
      end
      ST_WAIT: begin
        if (taken_s) begin
          redirect_s = 1'b1;
        end else if (in_imem_ack) begin
          load_s       = 1'b1;
          state_next_s = ST_HOLD;
        end else if (cnt_r == TIMEOUT_LAST) begin
          set_err_s    = 1'b1;
          state_next_s = ST_ERR;
        end else begin
          cnt_inc_s = 1'b1;
        end
      end
      ST_HOLD: begin
        if (taken_s) begin
          redirect_s = 1'b1;
        end else if (!in_stall) begin
          clr_valid_s  = 1'b1;
          state_next_s = ST_FETCH;
        end else begin
          state_next_s = ST_HOLD;
        end
      end
      ST_ERR: begin
        clr_valid_s  = 1'b1;
        state_next_s = ST_ERR;
      end
      default: begin
        state_next_s = ST_FETCH;
      end
    endcase
    if (redirect_s) begin
      clr_valid_s  = 1'b1;
      state_next_s = ST_FETCH;
    end else begin
      clr_valid_s  = clr_valid_s;
    end
  end

  // FSM state register.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // PC, captured instruction, flags and WAIT counter.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      pc_r       <= RESET_PC;
      instr_r    <= 32'd0;
      instr_pc_r <= '0;
      valid_r    <= 1'b0;
      flush_r    <= 1'b0;
      err_r      <= 1'b0;
      cnt_r      <= '0;
    end else begin
      flush_r <= redirect_s;
      if (redirect_s) begin
        pc_r <= in_target;
      end else if (load_s) begin
        pc_r <= pc_r + PC_W'(1);
      end
      if (load_s) begin
        instr_r    <= in_imem_data;
        instr_pc_r <= pc_r;
        valid_r    <= 1'b1;
      end else if (clr_valid_s) begin
        valid_r <= 1'b0;
      end
      if (cnt_clr_s) begin
        cnt_r <= '0;
      end else if (cnt_inc_s) begin
        cnt_r <= sat_inc(cnt_r);
      end
      if (set_err_s) begin
        err_r <= 1'b1;
      end
    end
  end

  // Request is a decode of the state register, held off while reset is applied.
  assign out_imem_req    = ((state_r == ST_FETCH) || (state_r == ST_WAIT)) && !in_rst;
  assign out_imem_addr   = pc_r;
  assign out_instr       = instr_r;
  assign out_instr_valid = valid_r;
  assign out_pc          = instr_pc_r;
  assign out_flush       = flush_r;
  assign out_err         = err_r;

endmodule
